// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI master/slave blocks.
package spi_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} spi_master_state_t;

    localparam int unsigned SPI_N           = 8;
    localparam int unsigned SPI_CLK_DIV     = 4;
    localparam logic [7:0]  SPI_SLAVE_REPLY = 8'h0A;

endpackage

// File: rtl/spi_sck_gen.sv
// SCK half-period timer: half_tick every CLK_DIV enabled cycles; SCK toggles on
// half_tick while sck_en is high and is held low otherwise.
module spi_sck_gen
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = SPI_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic sck_en,
    output logic half_tick,
    output logic SCK
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign half_tick = en && (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            SCK <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            SCK <= 1'b0;
        end else begin
            cnt <= half_tick ? '0 : cnt + 1'b1;
            if (!sck_en)
                SCK <= 1'b0;
            else if (half_tick)
                SCK <= ~SCK;
        end
    end

endmodule

// File: rtl/spi_master_arb.sv
// Arbitrated mode-0 SPI master shared by NREQ requesters.
// SPI_MASTER_ARB_RR_EN selects round-robin; otherwise fixed priority, req[0] highest.
module spi_master_arb
    import spi_pkg::*;
#(
    parameter int unsigned N       = SPI_N,
    parameter int unsigned NREQ    = 2,
    parameter int unsigned CLK_DIV = SPI_CLK_DIV
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] tx_data,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic [N-1:0]      rx_data,
    output logic              busy,
    output logic              SCK,
    output logic              CS,
    output logic              MOSI,
    input  logic              MISO
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned BW = (N > 1) ? $clog2(N) : 1;

    if (CLK_DIV < 4) begin : g_clk_div_chk
        $error("spi_master_arb: CLK_DIV must be at least 4");
    end
    if (NREQ < 2 || NREQ > 8) begin : g_nreq_chk
        $error("spi_master_arb: NREQ must be in 2..8");
    end

    spi_master_state_t state, state_nx;

    logic [IW-1:0] start_idx, cand, win_idx;
    logic          win_vld;
    logic [N-1:0]  win_word;
    logic [N-1:0]  tx_sh, rx_sh;
    logic [BW-1:0] bit_cnt;
    logic          half_tick, gen_en, sck_en;
    logic          load, sample, shift, bit_dec, finish;

`ifdef SPI_MASTER_ARB_RR_EN
    logic [IW-1:0] rr_ptr;

    assign start_idx = rr_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rr_ptr <= '0;
        else if (load)
            rr_ptr <= IW'((32'(win_idx) + 1) % NREQ);
    end
`else
    assign start_idx = '0;
`endif

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IW'((32'(start_idx) + i) % NREQ);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
        win_word = tx_data[32'(win_idx) * N +: N];
    end

    assign gen_en = (state != IDLE);
    // SCK must stay low through the final low half of bit 0 even though ticks continue.
    assign sck_en = (state == SETUP) || ((state == SHIFT) && !(!SCK && bit_cnt == '0));
    assign busy   = (state != IDLE);
    assign MOSI   = tx_sh[N-1];

    spi_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk       (clk),
        .reset     (reset),
        .en        (gen_en),
        .sck_en    (sck_en),
        .half_tick (half_tick),
        .SCK       (SCK)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        sample   = 1'b0;
        shift    = 1'b0;
        bit_dec  = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    load     = 1'b1;
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                if (half_tick) begin
                    sample   = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (half_tick) begin
                    if (SCK)
                        shift = (bit_cnt != '0);
                    else if (bit_cnt == '0)
                        state_nx = HOLD;
                    else begin
                        sample  = 1'b1;
                        bit_dec = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (half_tick) begin
                    finish   = 1'b1;
                    state_nx = GAP;
                end
            end
            GAP: begin
                if (half_tick)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant   <= '0;
            done    <= '0;
            rx_data <= '0;
            CS      <= 1'b1;
            tx_sh   <= '0;
            rx_sh   <= '0;
            bit_cnt <= '0;
        end else begin
            done <= '0;
            if (load) begin
                grant   <= NREQ'(1) << win_idx;
                CS      <= 1'b0;
                tx_sh   <= win_word;
                bit_cnt <= BW'(N - 1);
            end
            if (sample)
                rx_sh <= {rx_sh[N-2:0], MISO};
            if (bit_dec)
                bit_cnt <= bit_cnt - 1'b1;
            if (shift)
                tx_sh <= tx_sh << 1;
            if (finish) begin
                CS      <= 1'b1;
                rx_data <= rx_sh;
                done    <= grant;
                grant   <= '0;
                tx_sh   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_arb.sv
// Scoreboard bench for spi_master_arb against a behavioural mode-0 SPI slave.
`timescale 1ns/1ps
module tb_spi_master_arb;
    import spi_pkg::*;

    localparam int unsigned N       = 8;
    localparam int unsigned NREQ    = 2;
    localparam int unsigned CLK_DIV = 4;

    logic        clk     = 1'b0;
    logic        reset   = 1'b0;
    logic [1:0]  req     = 2'b00;
    logic [15:0] tx_data = 16'h0000;
    logic [1:0]  grant, done;
    logic [7:0]  rx_data;
    logic        busy, SCK, CS, MOSI, MISO;

    always #5 clk = ~clk;

    spi_master_arb #(.N(N), .NREQ(NREQ), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .reset(reset), .req(req), .tx_data(tx_data),
        .grant(grant), .done(done), .rx_data(rx_data), .busy(busy),
        .SCK(SCK), .CS(CS), .MOSI(MOSI), .MISO(MISO)
    );

    // Slave model: reply loaded on CS fall, shifted out on SCK fall; MOSI captured on SCK rise.
    logic [7:0] sl_sh     = 8'h00;
    logic [7:0] mosi_cap  = 8'h00;
    bit         miso_ones = 1'b0;

    always @(negedge CS) begin
        sl_sh    = SPI_SLAVE_REPLY;
        mosi_cap = 8'h00;
    end
    always @(negedge SCK) if (!CS) sl_sh = {sl_sh[6:0], 1'b0};
    always @(posedge SCK) mosi_cap = {mosi_cap[6:0], MOSI};
    assign MISO = miso_ones ? 1'b1 : (CS ? 1'b0 : sl_sh[7]);

    typedef struct {
        logic [1:0] owner;
        logic [7:0] rx;
        logic [7:0] word;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic test_reset();
        req   = 2'b00;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (CS !== 1'b1)      begin n_fail++; $display("FAIL reset_cs got %b want 1", CS); end
        n_tests++; if (SCK !== 1'b0)     begin n_fail++; $display("FAIL reset_sck got %b want 0", SCK); end
        n_tests++; if (MOSI !== 1'b0)    begin n_fail++; $display("FAIL reset_mosi got %b want 0", MOSI); end
        n_tests++; if (grant !== 2'b00)  begin n_fail++; $display("FAIL reset_grant got %b want 00", grant); end
        n_tests++; if (done !== 2'b00)   begin n_fail++; $display("FAIL reset_done got %b want 00", done); end
        n_tests++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx got %h want 00", rx_data); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int   done_at = -1;
        int   cs_low  = 0;
        exp_t e;
        tx_data[7:0] = 8'hA5;
        req          = 2'b01;
        sb.push_back(exp_t'{owner: 2'b01, rx: SPI_SLAVE_REPLY, word: 8'hA5});
        @(posedge clk);
        @(negedge clk);
        req = 2'b00;
        n_tests++; if (grant !== 2'b01) begin n_fail++; $display("FAIL single_grant got %b want 01", grant); end
        if (CS === 1'b0) cs_low++;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (CS === 1'b0) cs_low++;
            if (done !== 2'b00 && done_at < 0) begin
                done_at = k;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    n_tests++; if (done !== e.owner)    begin n_fail++; $display("FAIL single_done got %b want %b", done, e.owner); end
                    n_tests++; if (rx_data !== e.rx)    begin n_fail++; $display("FAIL single_rx got %h want %h", rx_data, e.rx); end
                    n_tests++; if (mosi_cap !== e.word) begin n_fail++; $display("FAIL single_mosi got %h want %h", mosi_cap, e.word); end
                end
            end
        end
        n_tests++; if (done_at != 72) begin n_fail++; $display("FAIL single_done_time got %0d want 72", done_at); end
        n_tests++; if (cs_low != 72)  begin n_fail++; $display("FAIL single_cs_low got %0d want 72", cs_low); end
        n_tests++; if (rx_data !== SPI_SLAVE_REPLY) begin n_fail++; $display("FAIL single_rx_hold got %h want %h", rx_data, SPI_SLAVE_REPLY); end
        sb.delete();
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_own [4];
        logic [1:0] got_own [4];
        int         g_at    [4];
        int         ng = 0;
        int         nd = 0;
        logic [1:0] prev_g = 2'b00;
        exp_t       e;
`ifdef SPI_MASTER_ARB_RR_EN
        exp_own = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_own = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        tx_data = {8'hC3, 8'h96};
        req     = 2'b11;
        reset   = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++)
            sb.push_back(exp_t'{owner: exp_own[i], rx: SPI_SLAVE_REPLY,
                                word: (exp_own[i] == 2'b01) ? 8'h96 : 8'hC3});
        reset = 1'b1;
        for (int k = 0; k < 400 && nd < 4; k++) begin
            @(negedge clk);
            if (grant !== 2'b00 && prev_g === 2'b00 && ng < 4) begin
                got_own[ng] = grant;
                g_at[ng]    = k;
                ng++;
            end
            prev_g = grant;
            if (done !== 2'b00) begin
                nd++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    n_tests++; if (done !== e.owner)    begin n_fail++; $display("FAIL b2b_done got %b want %b", done, e.owner); end
                    n_tests++; if (rx_data !== e.rx)    begin n_fail++; $display("FAIL b2b_rx got %h want %h", rx_data, e.rx); end
                    n_tests++; if (mosi_cap !== e.word) begin n_fail++; $display("FAIL b2b_mosi got %h want %h", mosi_cap, e.word); end
                end
            end
        end
        req = 2'b00;
        n_tests++; if (ng != 4) begin n_fail++; $display("FAIL b2b_grant_count got %0d want 4", ng); end
        n_tests++; if (nd != 4) begin n_fail++; $display("FAIL b2b_done_count got %0d want 4", nd); end
        for (int i = 0; i < ng; i++) begin
            n_tests++;
            if (got_own[i] !== exp_own[i]) begin n_fail++; $display("FAIL b2b_grant%0d got %b want %b", i, got_own[i], exp_own[i]); end
        end
        for (int i = 1; i < ng; i++) begin
            n_tests++;
            if (g_at[i] - g_at[i-1] != 77) begin n_fail++; $display("FAIL b2b_spacing%0d got %0d want 77", i, g_at[i] - g_at[i-1]); end
        end
        sb.delete();
        repeat (10) @(negedge clk);
    endtask

    task automatic test_req_pulse();
        int   done_at = -1;
        int   extra   = 0;
        exp_t e;
        tx_data[15:8] = 8'h5C;
        req           = 2'b10;
        sb.push_back(exp_t'{owner: 2'b10, rx: SPI_SLAVE_REPLY, word: 8'h5C});
        @(posedge clk);
        @(negedge clk);
        req = 2'b00;
        n_tests++; if (grant !== 2'b10) begin n_fail++; $display("FAIL pulse_grant got %b want 10", grant); end
        for (int k = 1; k <= 160; k++) begin
            @(negedge clk);
            if (k > 72 && grant !== 2'b00) extra++;
            if (done !== 2'b00 && done_at < 0) begin
                done_at = k;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    n_tests++; if (done !== e.owner)    begin n_fail++; $display("FAIL pulse_done got %b want %b", done, e.owner); end
                    n_tests++; if (mosi_cap !== e.word) begin n_fail++; $display("FAIL pulse_mosi got %h want %h", mosi_cap, e.word); end
                end
            end
        end
        n_tests++; if (done_at != 72) begin n_fail++; $display("FAIL pulse_done_time got %0d want 72", done_at); end
        n_tests++; if (extra != 0)    begin n_fail++; $display("FAIL pulse_regrant got %0d cycles want 0", extra); end
        sb.delete();
    endtask

    task automatic test_tx_change();
        int   done_at = -1;
        exp_t e;
        tx_data[7:0] = 8'h3C;
        req          = 2'b01;
        sb.push_back(exp_t'{owner: 2'b01, rx: SPI_SLAVE_REPLY, word: 8'h3C});
        @(posedge clk);
        @(negedge clk);
        req = 2'b00;
        repeat (2) @(negedge clk);
        tx_data[7:0] = 8'hFF;
        for (int k = 3; k <= 100 && done_at < 0; k++) begin
            @(negedge clk);
            if (done !== 2'b00) begin
                done_at = k;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    n_tests++; if (mosi_cap !== e.word) begin n_fail++; $display("FAIL txchg_mosi got %h want %h", mosi_cap, e.word); end
                    n_tests++; if (rx_data !== e.rx)    begin n_fail++; $display("FAIL txchg_rx got %h want %h", rx_data, e.rx); end
                end
            end
        end
        n_tests++; if (done_at != 72) begin n_fail++; $display("FAIL txchg_done_time got %0d want 72", done_at); end
        sb.delete();
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int   n_done  = 0;
        int   done_at = -1;
        exp_t e;
        tx_data[7:0] = 8'h81;
        req          = 2'b01;
        @(posedge clk);
        @(negedge clk);
        req = 2'b00;
        repeat (29) @(negedge clk);
        reset = 1'b0;
        #1;
        n_tests++; if (CS !== 1'b1)     begin n_fail++; $display("FAIL rmid_cs got %b want 1", CS); end
        n_tests++; if (SCK !== 1'b0)    begin n_fail++; $display("FAIL rmid_sck got %b want 0", SCK); end
        n_tests++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rmid_grant got %b want 00", grant); end
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k == 3) reset = 1'b1;
            if (done !== 2'b00) n_done++;
        end
        n_tests++; if (n_done != 0) begin n_fail++; $display("FAIL rmid_done got %0d pulses want 0", n_done); end
        tx_data[7:0] = 8'h4B;
        req          = 2'b01;
        sb.push_back(exp_t'{owner: 2'b01, rx: SPI_SLAVE_REPLY, word: 8'h4B});
        @(posedge clk);
        @(negedge clk);
        req = 2'b00;
        for (int k = 1; k <= 100 && done_at < 0; k++) begin
            @(negedge clk);
            if (done !== 2'b00) begin
                done_at = k;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    n_tests++; if (rx_data !== e.rx)    begin n_fail++; $display("FAIL rmid_rx got %h want %h", rx_data, e.rx); end
                    n_tests++; if (mosi_cap !== e.word) begin n_fail++; $display("FAIL rmid_mosi got %h want %h", mosi_cap, e.word); end
                end
            end
        end
        n_tests++; if (done_at != 72) begin n_fail++; $display("FAIL rmid_done_time got %0d want 72", done_at); end
        sb.delete();
        repeat (10) @(negedge clk);
    endtask

    task automatic test_miso_ones();
        int   busy_hi = 0;
        int   busy_76 = -1;
        int   done_at = -1;
        exp_t e;
        miso_ones    = 1'b1;
        tx_data[7:0] = 8'h42;
        req          = 2'b01;
        sb.push_back(exp_t'{owner: 2'b01, rx: 8'hFF, word: 8'h42});
        @(posedge clk);
        @(negedge clk);
        req = 2'b00;
        if (busy === 1'b1) busy_hi++;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (k <= 75 && busy === 1'b1) busy_hi++;
            if (k == 76) busy_76 = (busy === 1'b1) ? 1 : 0;
            if (done !== 2'b00 && done_at < 0) begin
                done_at = k;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    n_tests++; if (rx_data !== e.rx)    begin n_fail++; $display("FAIL ones_rx got %h want %h", rx_data, e.rx); end
                    n_tests++; if (mosi_cap !== e.word) begin n_fail++; $display("FAIL ones_mosi got %h want %h", mosi_cap, e.word); end
                end
            end
        end
        n_tests++; if (done_at != 72) begin n_fail++; $display("FAIL ones_done_time got %0d want 72", done_at); end
        n_tests++; if (busy_hi != 76) begin n_fail++; $display("FAIL ones_busy_high got %0d cycles want 76", busy_hi); end
        n_tests++; if (busy_76 != 0)  begin n_fail++; $display("FAIL ones_busy_end got %0d want 0", busy_76); end
        miso_ones = 1'b0;
        sb.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_req_pulse();
        test_tx_change();
        test_reset_mid();
        test_miso_ones();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
